// File: rtl/pwr_seq.sv
// Power-switch / supply-good sequencer feeding the PUKS power/reset unit.
// Debounces sw_on and pgood, times the ramp, and drives off, pon and pout.
module pwr_seq #(
  parameter int DEB_CYCLES = 16,
  parameter int ON_DELAY   = 1000,
  parameter int STROBE_LEN = 4,
  parameter int POUT_LEAD  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_on,
  input  logic       pgood,
  output logic       off,
  output logic       pon,
  output logic       pout,
  output logic [1:0] state
);

  localparam int MAX_A = (ON_DELAY > POUT_LEAD) ? ON_DELAY : POUT_LEAD;
  localparam int MAXP  = (MAX_A > STROBE_LEN) ? MAX_A : STROBE_LEN;
  localparam int CW    = $clog2(MAXP + 1);
  localparam int DW    = $clog2(DEB_CYCLES + 1);

  localparam logic [CW-1:0] RAMP_END = CW'(ON_DELAY - 1);
  localparam logic [CW-1:0] STR_END  = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] LEAD_END = CW'(POUT_LEAD - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAXP);
  localparam logic [DW-1:0] DEB_END  = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    DOWN = 2'd0,
    RAMP = 2'd1,
    UP   = 2'd2,
    WARN = 2'd3
  } st_t;

  // bit 0 = switch, bit 1 = supply good
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    db;
  logic [DW-1:0] dc [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      db    <= '0;
      dc[0] <= '0;
      dc[1] <= '0;
    end else begin
      s1 <= {pgood, sw_on};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          dc[i] <= '0;
        end else if (dc[i] == DEB_END) begin
          db[i] <= ~db[i];
          dc[i] <= '0;
        end else begin
          dc[i] <= dc[i] + 1'b1;
        end
      end
    end
  end

  logic          go;
  st_t           st;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign go      = db[0] & db[1];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign state   = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= DOWN;
      cnt  <= '0;
      off  <= 1'b1;
      pon  <= 1'b0;
      pout <= 1'b0;
    end else begin
      unique case (st)
        DOWN: begin
          if (go) begin
            st  <= RAMP;
            cnt <= '0;
          end
        end
        RAMP: begin
          if (!go) begin
            st  <= DOWN;
            cnt <= '0;
          end else if (cnt == RAMP_END) begin
            st  <= UP;
            cnt <= '0;
            off <= 1'b0;
            pon <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        UP: begin
          if (!go) begin
            st   <= WARN;
            cnt  <= '0;
            pon  <= 1'b0;
            pout <= 1'b1;
          end else if (pon) begin
            if (cnt == STR_END) pon <= 1'b0;
            else cnt <= cnt_inc;
          end
        end
        WARN: begin
          // go is ignored here: the warning always runs to completion
          if (cnt == LEAD_END) begin
            st   <= DOWN;
            cnt  <= '0;
            off  <= 1'b1;
            pout <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (cnt == STR_END) pout <= 1'b0;
          end
        end
        default: st <= DOWN;
      endcase
    end
  end

endmodule

// File: tb/tb_pwr_seq.sv
// Self-checking bench for pwr_seq: random input activity checked every
// cycle against a timestamp/window model of the sequencer.
module tb_pwr_seq;

  localparam int DEB = 16;
  localparam int OND = 1000;
  localparam int SL  = 4;
  localparam int PL  = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_on = 1'b0;
  logic       pgood = 1'b0;
  logic       off;
  logic       pon;
  logic       pout;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwr_seq #(
    .DEB_CYCLES(DEB),
    .ON_DELAY  (OND),
    .STROBE_LEN(SL),
    .POUT_LEAD (PL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw_on(sw_on),
    .pgood(pgood),
    .off  (off),
    .pon  (pon),
    .pout (pout),
    .state(state)
  );

  // model: raw-sample history per input, phase + entry timestamp
  int m_t     = 0;
  int m_enter = 0;
  int m_st    = 0;
  bit m_sw_db;
  bit m_pg_db;
  bit hs[$];
  bit hp[$];

  // a debounced value flips once the last DEB synchronized samples all differ
  function automatic bit win_differs(input bit q[$], input bit db);
    int n = q.size();
    for (int i = n - 2 - DEB; i <= n - 3; i++)
      if (q[i] == db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    hs.delete();
    hp.delete();
    repeat (DEB + 2) begin
      hs.push_back(1'b0);
      hp.push_back(1'b0);
    end
    m_sw_db = 1'b0;
    m_pg_db = 1'b0;
    m_st    = 0;
    m_enter = m_t;
  endtask

  task automatic m_step();
    bit go;
    int el;
    go = m_sw_db & m_pg_db;
    m_t++;
    el = m_t - m_enter;
    hs.push_back(sw_on);
    hp.push_back(pgood);
    case (m_st)
      0: if (go) begin m_st = 1; m_enter = m_t; end
      1: begin
        if (!go) begin m_st = 0; m_enter = m_t; end
        else if (el == OND) begin m_st = 2; m_enter = m_t; end
      end
      2: if (!go) begin m_st = 3; m_enter = m_t; end
      default: if (el == PL) begin m_st = 0; m_enter = m_t; end
    endcase
    if (win_differs(hs, m_sw_db)) m_sw_db = !m_sw_db;
    if (win_differs(hp, m_pg_db)) m_pg_db = !m_pg_db;
    while (hs.size() > DEB + 2) void'(hs.pop_front());
    while (hp.size() > DEB + 2) void'(hp.pop_front());
  endtask

  function automatic logic [4:0] expv();
    int el = m_t - m_enter;
    logic e_off, e_pon, e_pout;
    e_off  = (m_st < 2);
    e_pon  = (m_st == 2) && (el < SL);
    e_pout = (m_st == 3) && (el < SL);
    return {e_off, e_pon, e_pout, 2'(m_st)};
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    sw_on = 1'b1;
    pgood = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({off, pon, pout, state} !== 5'b10000) begin
      bad++;
      $display("FAIL reset got=%b want=10000", {off, pon, pout, state});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_power_up();
    int rel = m_t;
    int first = -1;
    for (int i = 0; i < 3 + DEB + OND + SL + 4; i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL power_up t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
      if (pon && first < 0) first = m_t - rel;
    end
    total++;
    if (first != 3 + DEB + OND) begin
      bad++;
      $display("FAIL power_up_latency got=%0d want=%0d", first, 3 + DEB + OND);
    end
  endtask

  task automatic test_power_down();
    int npon = 0;
    int npout = 0;
    sw_on = 1'b0;
    for (int i = 0; i < DEB + 3 + PL + 6; i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL power_down t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
      npon += int'(pon);
      npout += int'(pout);
    end
    total++;
    if (npon != 0 || npout != SL || state !== 2'd0) begin
      bad++;
      $display("FAIL power_down_strobes pon=%0d pout=%0d st=%0d want 0 %0d 0", npon, npout, SL, state);
    end
  endtask

  task automatic test_glitch();
    int t_rest = 0;
    int first = -1;
    bit strobed = 1'b0;
    bit was_down = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      sw_on = 1'b1;
      pgood = 1'b1;
      for (int i = 0; i < OND && !(m_st == 1 && m_t - m_enter == 500); i++) begin
        @(posedge clk); #1; total++;
        if ({off, pon, pout, state} !== expv()) begin
          bad++;
          $display("FAIL glitch_wait t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
        end
      end
      pgood = 1'b0;
      for (int i = 0; i < (pass == 0 ? 10 : 20); i++) begin
        @(posedge clk); #1; total++;
        if ({off, pon, pout, state} !== expv()) begin
          bad++;
          $display("FAIL glitch_low t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
        end
      end
      pgood = 1'b1;
      t_rest = m_t;
      first = -1;
      strobed = 1'b0;
      was_down = 1'b0;
      for (int i = 0; i < 3 + DEB + OND + 4 && first < 0; i++) begin
        @(posedge clk); #1; total++;
        if ({off, pon, pout, state} !== expv()) begin
          bad++;
          $display("FAIL glitch_run t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
        end
        if (state == 2'd0) was_down = 1'b1;
        if (pout) strobed = 1'b1;
        if (pon && first < 0) first = m_t - t_rest;
      end
      total++;
      if (pass == 0 && (was_down || first != OND - 500 - 10)) begin
        bad++;
        $display("FAIL glitch_short down=%0d pon_at=%0d want 0 %0d", was_down, first, OND - 510);
      end
      if (pass == 1 && (!was_down || strobed || first != 3 + DEB + OND)) begin
        bad++;
        $display("FAIL glitch_long down=%0d pout=%0d pon_at=%0d want 1 0 %0d", was_down, strobed, first, 3 + DEB + OND);
      end
      if (pass == 0) begin
        sw_on = 1'b0;
        for (int i = 0; i < DEB + PL + 10; i++) begin
          @(posedge clk); #1; total++;
          if ({off, pon, pout, state} !== expv()) begin
            bad++;
            $display("FAIL glitch_off t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
          end
        end
      end
    end
  endtask

  task automatic test_pon_cut();
    int npon = 0;
    int npout = 0;
    int both = 0;
    pgood = 1'b0;
    for (int i = 0; i < DEB + PL + 10; i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL pon_cut_off t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
    end
    pgood = 1'b1;
    for (int i = 0; i < OND + 40 && !(m_st == 1 && m_t - m_enter == OND - 1 - DEB); i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL pon_cut_ramp t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
    end
    pgood = 1'b0;
    for (int i = 0; i < DEB + PL + 10; i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL pon_cut_run t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
      npon += int'(pon);
      npout += int'(pout);
      both += int'(pon & pout);
    end
    total++;
    if (npon != 2 || npout != SL || both != 0) begin
      bad++;
      $display("FAIL pon_cut pon=%0d pout=%0d both=%0d want 2 %0d 0", npon, npout, both, SL);
    end
  endtask

  task automatic test_reset_mid();
    int rel;
    int first = -1;
    pgood = 1'b1;
    sw_on = 1'b1;
    for (int i = 0; i < 3 + DEB + OND + 10 && m_st != 2; i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL rst_mid_up t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
    end
    sw_on = 1'b0;
    for (int i = 0; i < DEB + 10 && !(m_st == 3 && m_t - m_enter == 1); i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL rst_mid_warn t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
    end
    total++;
    if (state !== 2'd3 || pout !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_reach st=%0d pout=%b want 3 1", state, pout);
    end
    sw_on = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({off, pon, pout, state} !== 5'b10000) begin
      bad++;
      $display("FAIL rst_mid_async got=%b want=10000", {off, pon, pout, state});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel = m_t;
    for (int i = 0; i < 3 + DEB + OND + 4; i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL rst_mid_ramp t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
      if (pon && first < 0) first = m_t - rel;
    end
    total++;
    if (first != 3 + DEB + OND) begin
      bad++;
      $display("FAIL rst_mid_latency got=%0d want=%0d", first, 3 + DEB + OND);
    end
  endtask

  task automatic test_back_to_back();
    int nwarn = 0;
    int npon = 0;
    sw_on = 1'b0;
    for (int i = 0; i < DEB + 10 && m_st != 3; i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL b2b_warn t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
    end
    sw_on = 1'b1;
    nwarn = int'(state == 2'd3);
    for (int i = 0; i < 3 + DEB + OND + PL + 8; i++) begin
      @(posedge clk); #1; total++;
      if ({off, pon, pout, state} !== expv()) begin
        bad++;
        $display("FAIL b2b_run t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
      end
      nwarn += int'(state == 2'd3);
      npon += int'(pon);
    end
    total++;
    if (nwarn != PL || npon != SL || state !== 2'd2) begin
      bad++;
      $display("FAIL b2b warn=%0d pon=%0d st=%0d want %0d %0d 2", nwarn, npon, state, PL, SL);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 4; seg++) begin
      sw_on = 1'b1;
      pgood = 1'b1;
      for (int i = 0; i < 3 + DEB + OND + 10 && m_st != 2; i++) begin
        @(posedge clk); #1; total++;
        if ({off, pon, pout, state} !== expv()) begin
          bad++;
          $display("FAIL random_up t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
        end
      end
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1; total++;
        if ({off, pon, pout, state} !== expv()) begin
          bad++;
          $display("FAIL random t=%0d got=%b want=%b", m_t, {off, pon, pout, state}, expv());
        end
        if ($urandom_range(24, 0) == 0) sw_on = ~sw_on;
        if ($urandom_range(24, 0) == 0) pgood = ~pgood;
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_glitch();
    test_pon_cut();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
